mdu_unit: RTL

//   Multiply/divide unit with architectural HI/LO registers for the P6 pipeline
//   (E stage). Runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, serves

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_compute.sv | 61 ++++++
 rtl/mdu_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared opcode encoding and constants for the E-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } mdop_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // Any opcode that touches the unit; used for the decode-stage stall request.
  function automatic logic is_md_op(input logic [3:0] op);
    logic res;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Opcodes that occupy the unit for multiple cycles.
  function automatic logic is_muldiv(input logic [3:0] op);
    logic res;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational multiply/divide datapath; result is captured by the top at start.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hiOut,
  output logic [31:0] loOut
);

  logic signed [63:0] smul_s;
  logic        [63:0] umul_s;
  logic signed [31:0] squot_s;
  logic signed [31:0] srem_s;
  logic        [31:0] uquot_s;
  logic        [31:0] urem_s;

  assign smul_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul_s  = {32'd0, A} * {32'd0, B};
  assign squot_s = $signed(A) / $signed(B);
  assign srem_s  = $signed(A) % $signed(B);
  assign uquot_s = A / B;
  assign urem_s  = A % B;

  // Result select; zero divisor and INT_MIN/-1 are pinned so the raw divider output is never used there.
  always_comb begin
    hiOut = 32'd0;
    loOut = 32'd0;
    case (mdop_e'(mdOp))
      MD_MULT:  {hiOut, loOut} = smul_s;
      MD_MULTU: {hiOut, loOut} = umul_s;
      MD_DIV: begin
        if (B == 32'd0) begin
          loOut = DIV0_QUOT;
          hiOut = A;
        end else if ((A == INT_MIN) && (B == 32'hFFFF_FFFF)) begin
          loOut = INT_MIN;
          hiOut = 32'd0;
        end else begin
          loOut = squot_s;
          hiOut = srem_s;
        end
      end
      MD_DIVU: begin
        if (B == 32'd0) begin
          loOut = DIV0_QUOT;
          hiOut = A;
        end else begin
          loOut = uquot_s;
          hiOut = urem_s;
        end
      end
      default: begin
        hiOut = 32'd0;
        loOut = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO: fixed-latency mult/div,
// MTHI/MTLO writes and combinational MFHI/MFLO forwarding to the E-stage ALU mux.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        mdStall,
  output logic [31:0] maluResult,
  output logic        mdSel
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e             state_r;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        hi_r;
  logic [31:0]        lo_r;
  logic [31:0]        pend_hi_r;
  logic [31:0]        pend_lo_r;
  logic [31:0]        calc_hi_s;
  logic [31:0]        calc_lo_s;

  mdu_compute u_compute (
    .mdOp  (mdOp),
    .A     (A),
    .B     (B),
    .hiOut (calc_hi_s),
    .loOut (calc_lo_s)
  );

  // Busy FSM, latency counter and HI/LO architectural state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (mdop_e'(mdOp))
              MD_MULT, MD_MULTU: begin
                pend_hi_r <= calc_hi_s;
                pend_lo_r <= calc_lo_s;
                cnt_r     <= CNT_W'(MULT_CYCLES - 1);
                state_r   <= ST_BUSY;
                busy_r    <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi_r <= calc_hi_s;
                pend_lo_r <= calc_lo_s;
                cnt_r     <= CNT_W'(DIV_CYCLES - 1);
                state_r   <= ST_BUSY;
                busy_r    <= 1'b1;
              end
              MD_MTHI: hi_r <= A;
              MD_MTLO: lo_r <= A;
              default: ;
            endcase
          end
        end
        // New ops arriving here are dropped; the hazard unit holds them via mdStall.
        ST_BUSY: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            hi_r    <= pend_hi_r;
            lo_r    <= pend_lo_r;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign mdStall = busy_r | (start & is_md_op(mdOp));

  // HI/LO read path into the E-stage result selector.
  always_comb begin
    maluResult = 32'd0;
    mdSel      = 1'b0;
    case (mdop_e'(mdOp))
      MD_MFHI: begin
        maluResult = hi_r;
        mdSel      = 1'b1;
      end
      MD_MFLO: begin
        maluResult = lo_r;
        mdSel      = 1'b1;
      end
      default: begin
        maluResult = 32'd0;
        mdSel      = 1'b0;
      end
    endcase
  end

endmodule
